// File: rtl/decode_instr_window_seq_if.sv
// Byte-intake, decoder-length and instruction-output bundle for the window sequencer.
interface decode_instr_window_seq_if;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic [71:0] window;
    logic [3:0]  win_count;
    logic        dec_len_valid;
    logic [3:0]  dec_len;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_instr;
    logic [3:0]  out_len;
    logic        err_bad_len;

    modport master (
        output flush, in_valid, in_byte, dec_len_valid, dec_len, out_ready,
        input  in_ready, window, win_count, out_valid, out_instr, out_len, err_bad_len
    );

    modport slave (
        input  flush, in_valid, in_byte, dec_len_valid, dec_len, out_ready,
        output in_ready, window, win_count, out_valid, out_instr, out_len, err_bad_len
    );
endinterface

// File: rtl/decode_instr_window_seq.sv
// Buffers instruction bytes in a 9-byte window, waits for the decoder's length
// and emits that many bytes as one instruction over valid/ready.
module decode_instr_window_seq #(
    parameter int WIN_BYTES = 9
) (
    input logic                      clk,
    input logic                      rst_n,
    decode_instr_window_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [3:0] FULL = 4'(WIN_BYTES);

    state_t                   state_q;
    logic [8*WIN_BYTES-1:0]   win_q;
    logic [3:0]               count_q;
    logic                     out_valid_q;
    logic [8*WIN_BYTES-1:0]   out_instr_q;
    logic [3:0]               out_len_q;
    logic                     err_q;

    logic                     in_ready;
    logic                     push;
    logic                     pop;
    logic                     len_ok;
    logic [3:0]               base;
    logic [8*WIN_BYTES-1:0]   shifted;
    logic [8*WIN_BYTES-1:0]   win_d;
    logic [3:0]               count_d;
    logic [8*WIN_BYTES-1:0]   masked;

    always_comb begin
        in_ready = (state_q != ST_ERROR) && (count_q < FULL) && !bus.flush;
        push     = bus.in_valid && in_ready;
        pop      = (state_q == ST_HOLD) && bus.out_ready;
        len_ok   = (bus.dec_len != 4'd0) && (bus.dec_len <= FULL);
    end

    // The pop is applied first so a same-cycle byte lands just above the survivors.
    always_comb begin
        base    = count_q;
        shifted = win_q;
        if (pop) begin
            base    = count_q - out_len_q;
            shifted = win_q >> {out_len_q, 3'b000};
        end
        win_d = shifted;
        for (int i = 0; i < WIN_BYTES; i++) begin
            if (push && (base == 4'(i))) begin
                win_d[8*i +: 8] = bus.in_byte;
            end
        end
        count_d = base + {3'b000, push};
    end

    always_comb begin
        masked = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            if (4'(i) < bus.dec_len) begin
                masked[8*i +: 8] = win_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            win_q       <= '0;
            count_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_len_q   <= 4'd0;
            err_q       <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= ST_FILL;
            win_q       <= '0;
            count_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_len_q   <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            win_q   <= win_d;
            count_q <= count_d;
            case (state_q)
                ST_FILL: begin
                    if (bus.dec_len_valid && len_ok && (count_q >= bus.dec_len)) begin
                        out_instr_q <= masked;
                        out_len_q   <= bus.dec_len;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else if (bus.dec_len_valid && !len_ok) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERROR;
                    end else if ((count_q == FULL) && !bus.dec_len_valid) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERROR;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_FILL;
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.window      = win_q;
    assign bus.win_count   = count_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_len     = out_len_q;
    assign bus.err_bad_len = err_q;

endmodule
